pwm_multi_gen: RTL
==================

Name: pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator, successor to the fixed single-rate LED/laser toggler. It drives CHANNELS independent duty-cycle outputs (LEDs, laser diode) from one shared period timebase. Duty values are written by the SPI command decoder through a simple write strobe. Writes are double-buffered so that a duty change takes effect only at a period boundary (glitch-free).

Parameters:
CLK_HZ, 48_000_000, input clock frequency in Hz
PWM_HZ, 400, target PWM refresh rate in Hz
RES_BITS, 8, duty resolution in bits; one period is 2^RES_BITS steps
CHANNELS, 2, number of PWM outputs (1..16)
ACTIVE_LOW, 0, 1 = all outputs inverted (active-low loads)

Ports:
CLK  in  1  system clock, CLK_HZ
RST  in  1  asynchronous, active-high reset
en  in  1  1 = run; 0 = hold timebase cleared, outputs inactive
wr_en  in  1  duty write strobe, one cycle, always accepted
wr_ch  in  max(1,$clog2(CHANNELS))  target channel of write
wr_duty  in  RES_BITS+1  duty in steps, 0..2^RES_BITS
pwm_o  out  CHANNELS  registered PWM outputs
period_start  out  1  one-cycle pulse at each period boundary
heartbeat  out  1  1 Hz status blink (see Optional Feature)

Behaviour:
- Derived constant STEP_CYCLES = CLK_HZ / (PWM_HZ * 2^RES_BITS), integer floor. Elaboration error if < 1. Actual period = STEP_CYCLES * 2^RES_BITS cycles. Defaults: 468, 119808 cycles, 400.64 Hz.
- Reset (async assert, sync deassert by CLK): prescaler = 0, step counter cnt = 0, all shadow/active duties = 0, pwm_o = inactive level (all 0, or all 1 if ACTIVE_LOW), period_start = 0.
- Prescaler counts 0..STEP_CYCLES-1. A tick is generated when it equals STEP_CYCLES-1, and the prescaler then wraps to 0. cnt (RES_BITS wide) increments on tick and wraps from 2^RES_BITS-1 to 0.
- Boundary: the cycle in which cnt wraps to 0 is a boundary. The first cycle with en=1 after reset or after en=0 is also a boundary. On a boundary:
  - every active duty <= shadow duty;
  - period_start pulses on the following cycle, aligned with the first pwm_o of the new period.
- Write: when wr_en=1 and wr_ch < CHANNELS, shadow[wr_ch] <= min(wr_duty, 2^RES_BITS). Writes with wr_ch >= CHANNELS are ignored.
- Write on a boundary cycle: active loads the pre-write shadow value; the new value applies from the next period.
- Output: raw[i] = (cnt < active[i]). pwm_o[i] <= raw[i] XOR ACTIVE_LOW. Latency is 1 cycle from cnt. Duty 0 = never active. Duty 2^RES_BITS = always active (100%).
- en=0: prescaler and cnt are held at 0, pwm_o is held inactive, no period_start. Shadow registers still accept writes; active values are retained.
- Outputs are glitch-free: pwm_o changes at most twice per period per channel.

Optional Feature:
Macro PWM_HEARTBEAT_EN.
- Defined: heartbeat toggles every CLK_HZ/2 cycles; reset value 1 (LED off, active-low). It runs regardless of en.
- Undefined: heartbeat is tied to constant 1 and no counter logic is synthesised.

Test Plan:
All scenarios use sim parameters CLK_HZ=64, PWM_HZ=1, RES_BITS=4, CHANNELS=2, ACTIVE_LOW=0 (STEP_CYCLES=4, period 64 cycles).
- Reset then en=1, write ch0=4, ch1=12 before the first boundary -> first period: pwm_o[0] high for 16 cycles and pwm_o[1] high for 48 cycles, both rising on the cycle period_start is high.
- Write ch0=8 mid-period -> current period keeps the old width; the next period is 32 cycles high.
- Write coincident with the boundary cycle -> old shadow applies this period, new value the next.
- Duty 0 and 16, plus wr_duty=31 (saturates to 16) -> constant low; constant high for all 64 cycles.
- ACTIVE_LOW=1, duty 4 -> low for 16 cycles, high for 48; reset value 1; en=0 forces 1. wr_ch=3 write -> no channel changes.
- RST asserted mid-period (asynchronous, between clock edges) -> pwm_o inactive immediately. Released with en=1 -> fresh period starting at cnt 0 with duties 0. With PWM_HEARTBEAT_EN, heartbeat toggles every 32 cycles.

Source files
------------

// File: rtl/pwm_multi_gen_if.sv
// Duty-write port of pwm_multi_gen: a one-cycle strobe with target channel and duty.
// The command decoder drives the master side; the PWM generator reads the slave side.
interface pwm_multi_gen_if #(
  parameter int CH_W   = 1,
  parameter int DUTY_W = 9
);
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DUTY_W-1:0] wr_duty;

  modport master (output wr_en, wr_ch, wr_duty);
  modport slave  (input  wr_en, wr_ch, wr_duty);
endinterface

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with a shared timebase and period-aligned duty updates.
// Optional heartbeat counter enabled by defining PWM_HEARTBEAT_EN.
module pwm_multi_gen #(
  parameter int CLK_HZ     = 48_000_000,
  parameter int PWM_HZ     = 400,
  parameter int RES_BITS   = 8,
  parameter int CHANNELS   = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  pwm_multi_gen_if.slave      wr,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                period_start,
  output logic                heartbeat
);

  localparam int STEPS       = 1 << RES_BITS;
  localparam int STEP_CYCLES = CLK_HZ / (PWM_HZ * STEPS);
  localparam int PS_W        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DUTY_W      = RES_BITS + 1;
  localparam logic [DUTY_W-1:0] FULL = DUTY_W'(STEPS);
  localparam logic INV       = (ACTIVE_LOW != 0);

  if (STEP_CYCLES < 1) begin : g_cfg_err
    $error("pwm_multi_gen: CLK_HZ too low for PWM_HZ * 2^RES_BITS");
  end

  function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] d);
    return (d > FULL) ? FULL : d;
  endfunction

  logic [PS_W-1:0]     r_ps, w_ps_nxt;
  logic [RES_BITS-1:0] r_cnt, w_cnt_nxt;
  logic                r_en_d;
  logic                w_first, w_tick, w_boundary;
  logic [DUTY_W-1:0]   r_shadow  [CHANNELS];
  logic [DUTY_W-1:0]   r_active  [CHANNELS];
  logic [DUTY_W-1:0]   w_act_nxt [CHANNELS];
  logic [CHANNELS-1:0] w_raw;

  // The first enabled cycle stands in for the wrap cycle, so the prescaler stays at 0 there.
  always_comb begin
    w_first    = en && !r_en_d;
    w_tick     = en && !w_first && (r_ps == PS_W'(STEP_CYCLES - 1));
    w_boundary = w_first || (w_tick && (r_cnt == '1));
    w_ps_nxt   = '0;
    w_cnt_nxt  = '0;
    if (en && !w_first) begin
      w_ps_nxt  = w_tick ? '0 : r_ps + 1'b1;
      w_cnt_nxt = w_tick ? r_cnt + 1'b1 : r_cnt;
    end
    // Compare against next-state count/duty so pwm_o lines up with period_start.
    for (int i = 0; i < CHANNELS; i++) begin
      w_act_nxt[i] = w_boundary ? r_shadow[i] : r_active[i];
      w_raw[i]     = en && ({1'b0, w_cnt_nxt} < w_act_nxt[i]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ps         <= '0;
      r_cnt        <= '0;
      r_en_d       <= 1'b0;
      period_start <= 1'b0;
      pwm_o        <= {CHANNELS{INV}};
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_ps         <= w_ps_nxt;
      r_cnt        <= w_cnt_nxt;
      r_en_d       <= en;
      period_start <= w_boundary;
      pwm_o        <= w_raw ^ {CHANNELS{INV}};
      for (int i = 0; i < CHANNELS; i++) begin
        r_active[i] <= w_act_nxt[i];
        if (wr.wr_en && (wr.wr_ch == CH_W'(i)))
          r_shadow[i] <= sat_duty(wr.wr_duty);
      end
    end
  end

`ifdef PWM_HEARTBEAT_EN
  localparam int HB_HALF = CLK_HZ / 2;
  localparam int HB_W    = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;

  logic [HB_W-1:0] r_hb_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hb_cnt  <= '0;
      heartbeat <= 1'b1;
    end else if (r_hb_cnt == HB_W'(HB_HALF - 1)) begin
      r_hb_cnt  <= '0;
      heartbeat <= ~heartbeat;
    end else begin
      r_hb_cnt  <= r_hb_cnt + 1'b1;
    end
  end
`else
  assign heartbeat = 1'b1;
`endif

endmodule
